// File: rtl/iagc_pkg.sv
// Shared definitions for the IAGC gain-control slice: FSM states, gain width,
// status word layout.
package iagc_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_DECIDE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } iagc_state_t;

  localparam int unsigned GAIN_W          = 3;
  localparam int unsigned STATUS_CLIP_BIT = 3;
  localparam int unsigned STATUS_GAIN_LSB = 0;

  typedef logic [GAIN_W-1:0] gain_t;

  localparam gain_t MAX_GAIN = 3'd7;

  // Pack clip flag and gain index into the 4-bit status word.
  function automatic logic [3:0] make_status(input logic clip, input gain_t gain);
    logic [3:0] s;
    s = '0;
    s[STATUS_CLIP_BIT] = clip;
    s[STATUS_GAIN_LSB +: GAIN_W] = gain;
    return s;
  endfunction

endpackage

// File: rtl/iagc_scale_sat.sv
// One channel: two's-complement sample shifted left by the gain index,
// saturated to the sample width, plus its unsigned magnitude.
module iagc_scale_sat
  import iagc_pkg::*;
#(
  parameter int unsigned DATA_W = 14
) (
  input  logic [DATA_W-1:0] data_in,
  input  gain_t             gain,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] magnitude,
  output logic              clip
);

  localparam int unsigned WIDE_W = DATA_W + 32'(MAX_GAIN);

  logic [WIDE_W-1:0]   wide;
  logic [WIDE_W-DATA_W:0] upper;

  // Shift in a widened domain; the result fits iff every bit above the
  // output sign bit equals that sign bit.
  always_comb begin
    wide      = {{(WIDE_W-DATA_W){data_in[DATA_W-1]}}, data_in} << gain;
    upper     = wide[WIDE_W-1:DATA_W-1];
    clip      = !((&upper) || (~|upper));
    data_out  = wide[DATA_W-1:0];
    if (clip) begin
      data_out = wide[WIDE_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    magnitude = data_out[DATA_W-1] ? (~data_out + DATA_W'(1)) : data_out;
  end

endmodule

// File: rtl/iagc_gain_ctrl.sv
// IAGC stage: two-stage scale/saturate pipeline for both Zmod channels with a
// per-window gain decision FSM. Optional manual gain override is enabled by
// defining IAGC_MANUAL_EN (adds i_manual / i_manual_gain).
module iagc_gain_ctrl
  import iagc_pkg::*;
#(
  parameter int unsigned ZMOD_DATA_SIZE   = 14,
  parameter int unsigned IAGC_STATUS_SIZE = 4,
  parameter int unsigned WINDOW_LOG2      = 10,
  parameter int unsigned HOLDOFF          = 16,
  parameter int unsigned TH_HIGH          = 6144,
  parameter int unsigned TH_LOW           = 3072,
  parameter int unsigned INIT_GAIN        = 0
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [ZMOD_DATA_SIZE-1:0]   i_data_ch1,
  input  logic [ZMOD_DATA_SIZE-1:0]   i_data_ch2,
  input  logic                        i_valid,
`ifdef IAGC_MANUAL_EN
  input  logic                        i_manual,
  input  logic [GAIN_W-1:0]           i_manual_gain,
`endif
  output logic [ZMOD_DATA_SIZE-1:0]   o_data_ch1,
  output logic [ZMOD_DATA_SIZE-1:0]   o_data_ch2,
  output logic                        o_sample,
  output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status
);

  localparam int unsigned N     = ZMOD_DATA_SIZE;
  localparam int unsigned CNT_W = (WINDOW_LOG2 + 1 > $clog2(HOLDOFF + 1)) ?
                                  WINDOW_LOG2 + 1 : $clog2(HOLDOFF + 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'((1 << WINDOW_LOG2) - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [N-1:0]     TH_HI_N   = N'(TH_HIGH);
  localparam logic [N-1:0]     TH_LO_N   = N'(TH_LOW);
  localparam gain_t            INIT_G    = GAIN_W'(INIT_GAIN);

  iagc_state_t state, state_next;
  gain_t       gain, gain_next;
  logic        manual_hold;
  gain_t       manual_gain;

  logic         s1_valid;
  logic [N-1:0] s1_ch1, s1_ch2;
  logic [N-1:0] sc1_out, sc2_out, sc1_mag, sc2_mag;
  logic         sc1_clip, sc2_clip;
  logic [N-1:0] s2_mag1, s2_mag2, sample_peak;
  logic         s2_clip;

  logic [N-1:0]                  peak;
  logic                          clip_seen;
  logic [CNT_W-1:0]              cnt;
  logic [IAGC_STATUS_SIZE-1:0]   status;

`ifdef IAGC_MANUAL_EN
  assign manual_hold = i_manual;
  assign manual_gain = i_manual_gain;
`else
  assign manual_hold = 1'b0;
  assign manual_gain = '0;
`endif

  iagc_scale_sat #(.DATA_W(N)) u_scale_ch1 (
    .data_in(s1_ch1), .gain(gain), .data_out(sc1_out), .magnitude(sc1_mag), .clip(sc1_clip)
  );

  iagc_scale_sat #(.DATA_W(N)) u_scale_ch2 (
    .data_in(s1_ch2), .gain(gain), .data_out(sc2_out), .magnitude(sc2_mag), .clip(sc2_clip)
  );

  assign sample_peak   = (s2_mag1 > s2_mag2) ? s2_mag1 : s2_mag2;
  assign o_iagc_status = status;

  // Data path: input register, then scale/saturate register; never stalls.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s1_valid   <= 1'b0;
      s1_ch1     <= '0;
      s1_ch2     <= '0;
      o_sample   <= 1'b0;
      o_data_ch1 <= '0;
      o_data_ch2 <= '0;
      s2_mag1    <= '0;
      s2_mag2    <= '0;
      s2_clip    <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_ch1 <= i_data_ch1;
        s1_ch2 <= i_data_ch2;
      end
      o_sample <= s1_valid;
      if (s1_valid) begin
        o_data_ch1 <= sc1_out;
        o_data_ch2 <= sc2_out;
        s2_mag1    <= sc1_mag;
        s2_mag2    <= sc2_mag;
        s2_clip    <= sc1_clip | sc2_clip;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_ACQUIRE;
    else         state <= state_next;
  end

  // Next state and gain decision; counting is on emitted output samples.
  always_comb begin
    state_next = state;
    gain_next  = gain;
    case (state)
      ST_ACQUIRE: if (o_sample && cnt == WIN_LAST) state_next = ST_DECIDE;
      ST_DECIDE: begin
        if (clip_seen || peak > TH_HI_N) begin
          if (gain != '0) gain_next = gain - 1'b1;
        end else if (peak < TH_LO_N) begin
          if (gain != MAX_GAIN) gain_next = gain + 1'b1;
        end
        state_next = (gain_next != gain) ? ST_HOLDOFF : ST_ACQUIRE;
      end
      ST_HOLDOFF: if (o_sample && cnt == HOLD_LAST) state_next = ST_ACQUIRE;
      default:    state_next = ST_ACQUIRE;
    endcase
    if (manual_hold) begin
      state_next = ST_ACQUIRE;
      gain_next  = manual_gain;
    end
  end

  // Window measurement, gain and status registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      gain      <= INIT_G;
      status    <= make_status(1'b0, INIT_G);
      peak      <= '0;
      clip_seen <= 1'b0;
      cnt       <= '0;
    end else begin
      gain <= gain_next;
      if (manual_hold) begin
        status    <= make_status(1'b0, manual_gain);
        peak      <= '0;
        clip_seen <= 1'b0;
        cnt       <= '0;
      end else begin
        case (state)
          ST_ACQUIRE: if (o_sample) begin
            if (sample_peak > peak) peak <= sample_peak;
            clip_seen <= clip_seen | s2_clip;
            cnt       <= cnt + 1'b1;
          end
          ST_DECIDE: begin
            status    <= make_status(clip_seen, gain_next);
            peak      <= '0;
            clip_seen <= 1'b0;
            cnt       <= '0;
          end
          ST_HOLDOFF: if (o_sample) cnt <= (cnt == HOLD_LAST) ? '0 : cnt + 1'b1;
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iagc_gain_ctrl.sv
// Directed testbench for iagc_gain_ctrl with a 16-sample window and holdoff 2.
module tb_iagc_gain_ctrl;

  localparam int unsigned N = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [N-1:0] d1, d2, q1, q2;
  logic         sample;
  logic [3:0]   status;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] sd [0:79];
  logic [3:0]   ss [0:79];

  always #5 clk = ~clk;

  iagc_gain_ctrl #(
    .ZMOD_DATA_SIZE(14), .IAGC_STATUS_SIZE(4), .WINDOW_LOG2(4), .HOLDOFF(2),
    .TH_HIGH(6144), .TH_LOW(3072), .INIT_GAIN(0)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_data_ch1(d1), .i_data_ch2(d2), .i_valid(valid),
`ifdef IAGC_MANUAL_EN
    .i_manual(1'b0), .i_manual_gain(3'd0),
`endif
    .o_data_ch1(q1), .o_data_ch2(q2), .o_sample(sample), .o_iagc_status(status)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; d1 = '0; d2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic collect(input int ncyc, output int nsamp);
    nsamp = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (sample && nsamp < 80) begin
        sd[nsamp] = q1;
        ss[nsamp] = status;
        nsamp++;
      end
    end
  endtask

  task automatic wait_status(input logic [3:0] s, input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc && !ok; c++) begin
      @(negedge clk);
      if (status == s) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; d1 = 14'd123; d2 = 14'd321;
    repeat (3) @(negedge clk);
    checks++;
    if (sample !== 1'b0 || q1 !== '0 || q2 !== '0 || status !== 4'h0) begin
      errors++;
      $display("FAIL reset: sample=%b ch1=%0d ch2=%0d status=%h, required 0/0/0/0", sample, q1, q2, status);
    end
    rst = 1'b0; valid = 1'b0;
  endtask

  task automatic test_gain_ramp();
    int n;
    int idx[8]            = '{0, 16, 17, 18, 35, 36, 37, 60};
    logic [N-1:0] ed[8]   = '{14'd1000, 14'd1000, 14'd1000, 14'd2000, 14'd2000, 14'd2000, 14'd4000, 14'd4000};
    logic [3:0]   es[8]   = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
    apply_reset();
    d1 = 14'd1000; d2 = 14'd1000; valid = 1'b1;
    collect(70, n);
    checks++;
    if (n < 61) begin
      errors++;
      $display("FAIL ramp_count: %0d samples, required at least 61", n);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (sd[idx[i]] !== ed[i] || ss[idx[i]] !== es[i]) begin
          errors++;
          $display("FAIL ramp_sample%0d: data=%0d status=%h, required %0d/%h",
                   idx[i], sd[idx[i]], ss[idx[i]], ed[i], es[i]);
        end
      end
    end
    checks++;
    if (q2 !== 14'd4000) begin
      errors++;
      $display("FAIL ramp_ch2: %0d, required 4000", q2);
    end
    valid = 1'b0;
  endtask

  task automatic test_clip();
    bit ok;
    bit found;
    logic [N-1:0] neg5000 = 14'h3FFF - 14'd4999;
    apply_reset();
    d1 = 14'd1000; d2 = 14'd1000; valid = 1'b1;
    wait_status(4'h1, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clip_setup: status=%h, required 1 within 60 cycles", status);
    end
    d1 = 14'd5000; d2 = neg5000;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (sample && q1 !== 14'd1000 && q1 !== 14'd2000) found = 1'b1;
    end
    checks++;
    if (!found || q1 !== 14'h1FFF || q2 !== 14'h2000) begin
      errors++;
      $display("FAIL clip_sat: ch1=%h ch2=%h, required 1fff/2000", q1, q2);
    end
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (status !== 4'h1) ok = 1'b1;
    end
    checks++;
    if (!ok || status !== 4'h8) begin
      errors++;
      $display("FAIL clip_status: %h, required 8", status);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q1 !== 14'd5000 || q2 !== neg5000) begin
      errors++;
      $display("FAIL clip_after: ch1=%h ch2=%h, required %h/%h", q1, q2, 14'd5000, neg5000);
    end
    repeat (25) @(negedge clk);
    checks++;
    if (status !== 4'h0) begin
      errors++;
      $display("FAIL clip_band: status=%h, required 0", status);
    end
    valid = 1'b0;
  endtask

  task automatic test_neg_floor();
    apply_reset();
    d1 = 14'h2000; d2 = 14'd100; valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sample !== 1'b1 || q1 !== 14'h2000 || q2 !== 14'd100) begin
      errors++;
      $display("FAIL neg_first: sample=%b ch1=%h ch2=%0d, required 1/2000/100", sample, q1, q2);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (status !== 4'h0 || q1 !== 14'h2000) begin
      errors++;
      $display("FAIL neg_floor: status=%h ch1=%h, required 0/2000", status, q1);
    end
    valid = 1'b0;
  endtask

  task automatic test_gain_ceiling();
    apply_reset();
    d1 = 14'd1; d2 = 14'h3FFF; valid = 1'b1;
    repeat (250) @(negedge clk);
    checks++;
    if (status !== 4'h7 || q1 !== 14'd128 || q2 !== 14'h3F80) begin
      errors++;
      $display("FAIL ceiling: status=%h ch1=%h ch2=%h, required 7/0080/3f80", status, q1, q2);
    end
    valid = 1'b0;
  endtask

  task automatic test_sparse_valid();
    int vq[$];
    int sent = 0;
    int k = 0;
    int head;
    logic [N-1:0] exp_d;
    logic [3:0]   exp_s;
    apply_reset();
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (sample) begin
        head = (vq.size() > 0) ? vq.pop_front() : -100;
        exp_d = (k < 16) ? N'(100 + k) : N'(2 * (100 + k));
        exp_s = (k < 16) ? 4'h0 : 4'h1;
        checks++;
        if (head != c - 2 || q1 !== exp_d || status !== exp_s) begin
          errors++;
          $display("FAIL sparse_sample%0d: cycle=%0d data=%0d status=%h, required cycle %0d data %0d status %h",
                   k, c, q1, status, head + 2, exp_d, exp_s);
        end
        k++;
      end
      if (c % 3 == 0 && sent < 34) begin
        valid = 1'b1; d1 = N'(100 + sent); d2 = 14'd50;
        vq.push_back(c);
        sent++;
      end else begin
        valid = 1'b0;
      end
    end
    checks++;
    if (k != 34 || vq.size() != 0) begin
      errors++;
      $display("FAIL sparse_count: %0d strobes, %0d pending, required 34/0", k, vq.size());
    end
  endtask

  task automatic test_reset_mid_window();
    bit ok;
    int n;
    int first1;
    apply_reset();
    d1 = 14'd100; d2 = 14'd100; valid = 1'b1;
    wait_status(4'h3, 120, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_setup: status=%h, required 3 within 120 cycles", status);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (status !== 4'h0 || sample !== 1'b0 || q1 !== '0) begin
      errors++;
      $display("FAIL midreset_state: status=%h sample=%b ch1=%0d, required 0/0/0", status, sample, q1);
    end
    rst = 1'b0;
    collect(24, n);
    first1 = -1;
    for (int i = n - 1; i >= 0; i--) if (ss[i] == 4'h1) first1 = i;
    checks++;
    if (n < 20 || sd[0] !== 14'd100 || first1 != 17 || sd[18] !== 14'd200) begin
      errors++;
      $display("FAIL midreset_window: n=%0d first=%0d gain1_at=%0d s18=%0d, required >=20/100/17/200",
               n, sd[0], first1, sd[18]);
    end
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; d1 = '0; d2 = '0;
    test_reset();
    test_gain_ramp();
    test_clip();
    test_neg_floor();
    test_gain_ceiling();
    test_sparse_valid();
    test_reset_mid_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
